// File: rtl/risc_pkg.sv
// Shared constants and types for the decode->execute operand fetch stage.
//   DATA_W   : operand / writeback data width
//   ADDR_W   : register address width (GPR read/write ports)
//   NUM_REGS : architected registers tracked by the busy scoreboard
//   CTRL_W   : opaque execute-control bundle width
//   ctrl_t   : execute-control bundle, passed through unmodified
package risc_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 1 << ADDR_W;
  localparam int CTRL_W   = 8;

  typedef logic [CTRL_W-1:0] ctrl_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Busy scoreboard: one flop per architected register marking an in-flight writer.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   set_en_i/set_idx_i  : mark a register busy (instruction issued that writes it)
//   clr_en_i/clr_idx_i  : writeback retires a register this cycle
//   flush_clr_en_i/_idx : flushed output entry drops its reservation
//   eff_busy_o          : busy with this cycle's writeback already removed, so the
//                         hazard check can let a dependent instruction go in the
//                         same cycle the producer writes back (value is forwarded)
module reg_scoreboard
  import risc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en_i,
  input  logic [ADDR_W-1:0]   set_idx_i,
  input  logic                clr_en_i,
  input  logic [ADDR_W-1:0]   clr_idx_i,
  input  logic                flush_clr_en_i,
  input  logic [ADDR_W-1:0]   flush_clr_idx_i,
  output logic [NUM_REGS-1:0] eff_busy_o
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] flush_mask;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_mask
    assign set_mask[gi]   = set_en_i       && (set_idx_i       == ADDR_W'(gi));
    assign clr_mask[gi]   = clr_en_i       && (clr_idx_i       == ADDR_W'(gi));
    assign flush_mask[gi] = flush_clr_en_i && (flush_clr_idx_i == ADDR_W'(gi));
  end

  assign eff_busy_o = busy_q & ~clr_mask;

  // Set is OR-ed in last so a new writer wins over a retiring one on the same register.
  assign busy_d = (busy_q & ~clr_mask & ~flush_mask) | set_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode->execute operand fetch stage.
// Accepts decoded instructions (in_valid/in_ready), drives both GPR read ports,
// stalls on RAW/WAW hazards via a busy scoreboard, forwards same-cycle writeback
// data, and registers operands + control toward execute (out_valid/out_ready).
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   in_*                             : decoded instruction and handshake
//   gpr_read_addr1/2, gpr_read_data1/2 : GPR read ports (combinational read)
//   wb_en, wb_dest, wb_data          : writeback bus (same as GPR write port)
//   flush                            : discard the held output entry
//   out_*                            : registered operands/control and handshake
module operand_fetch_stage
  import risc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic              in_use_rs1,
  input  logic              in_use_rs2,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_rd_we,
  input  logic [DATA_W-1:0] in_imm,
  input  ctrl_t             in_ctrl,
  output logic [ADDR_W-1:0] gpr_read_addr1,
  output logic [ADDR_W-1:0] gpr_read_addr2,
  input  logic [DATA_W-1:0] gpr_read_data1,
  input  logic [DATA_W-1:0] gpr_read_data2,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_op_a,
  output logic [DATA_W-1:0] out_op_b,
  output logic [DATA_W-1:0] out_imm,
  output ctrl_t             out_ctrl,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_rd_we
);

  logic [NUM_REGS-1:0] eff_busy;
  logic                hazard;
  logic                fire;
  logic [DATA_W-1:0]   op_a_d;
  logic [DATA_W-1:0]   op_b_d;

  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   op_a_q, op_b_q, imm_q;
  ctrl_t               ctrl_q;
  logic [ADDR_W-1:0]   rd_q;
  logic                rd_we_q;

  assign gpr_read_addr1 = in_rs1;
  assign gpr_read_addr2 = in_rs2;

  // WAW is included so each register has at most one in-flight writer,
  // which keeps the single busy bit per register sufficient.
  assign hazard = (in_use_rs1 & eff_busy[in_rs1])
                | (in_use_rs2 & eff_busy[in_rs2])
                | (in_rd_we   & eff_busy[in_rd]);

  assign in_ready = ~hazard & ~flush & (~out_valid_q | out_ready);
  assign fire     = in_valid & in_ready;

  // The GPR file only shows a write on the following cycle, so bypass it.
  assign op_a_d = (wb_en && (wb_dest == in_rs1)) ? wb_data : gpr_read_data1;
  assign op_b_d = (wb_en && (wb_dest == in_rs2)) ? wb_data : gpr_read_data2;

  reg_scoreboard u_sb (
    .clk             (clk),
    .rst             (rst),
    .set_en_i        (fire & in_rd_we),
    .set_idx_i       (in_rd),
    .clr_en_i        (wb_en),
    .clr_idx_i       (wb_dest),
    .flush_clr_en_i  (flush & out_valid_q & rd_we_q),
    .flush_clr_idx_i (rd_q),
    .eff_busy_o      (eff_busy)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (fire) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      imm_q       <= '0;
      ctrl_q      <= '0;
      rd_q        <= '0;
      rd_we_q     <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (fire) begin
        op_a_q  <= op_a_d;
        op_b_q  <= op_b_d;
        imm_q   <= in_imm;
        ctrl_q  <= in_ctrl;
        rd_q    <= in_rd;
        rd_we_q <= in_rd_we;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_op_a  = op_a_q;
  assign out_op_b  = op_b_q;
  assign out_imm   = imm_q;
  assign out_ctrl  = ctrl_q;
  assign out_rd    = rd_q;
  assign out_rd_we = rd_we_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
module tb_operand_fetch_stage;
  import risc_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_rs1, in_rs2, in_rd;
  logic              in_use_rs1, in_use_rs2, in_rd_we;
  logic [DATA_W-1:0] in_imm;
  ctrl_t             in_ctrl;
  logic [ADDR_W-1:0] gpr_read_addr1, gpr_read_addr2;
  logic [DATA_W-1:0] gpr_read_data1, gpr_read_data2;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_dest;
  logic [DATA_W-1:0] wb_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_op_a, out_op_b, out_imm;
  ctrl_t             out_ctrl;
  logic [ADDR_W-1:0] out_rd;
  logic              out_rd_we;

  logic [DATA_W-1:0] gpr [NUM_REGS];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Small GPR model with combinational read (stale w.r.t. wb in the same cycle).
  assign gpr_read_data1 = gpr[gpr_read_addr1];
  assign gpr_read_data2 = gpr[gpr_read_addr2];

  operand_fetch_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
    .in_rd(in_rd), .in_rd_we(in_rd_we),
    .in_imm(in_imm), .in_ctrl(in_ctrl),
    .gpr_read_addr1(gpr_read_addr1), .gpr_read_addr2(gpr_read_addr2),
    .gpr_read_data1(gpr_read_data1), .gpr_read_data2(gpr_read_data2),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op_a(out_op_a), .out_op_b(out_op_b),
    .out_imm(out_imm), .out_ctrl(out_ctrl),
    .out_rd(out_rd), .out_rd_we(out_rd_we)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-22s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic v, input logic [2:0] rs1, input logic u1,
                       input logic [2:0] rs2, input logic u2,
                       input logic [2:0] rd, input logic we,
                       input logic [31:0] imm, input logic [7:0] ctrl);
    in_valid = v; in_rs1 = rs1; in_use_rs1 = u1; in_rs2 = rs2; in_use_rs2 = u2;
    in_rd = rd; in_rd_we = we; in_imm = imm; in_ctrl = ctrl;
    #1;
  endtask

  initial begin
    for (int i = 0; i < NUM_REGS; i++) gpr[i] = 32'h100 + i;
    gpr[1] = 32'd5;
    gpr[2] = 32'd7;
    wb_en = 0; wb_dest = 0; wb_data = 0; flush = 0; out_ready = 1;
    rst = 1;

    // 1 Reset with in_valid=1: reset dominates.
    instr(1, 3'd1, 1, 3'd2, 1, 3'd3, 1, 32'hDEAD, 8'hFF);
    tick();
    tick();
    rst = 0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_op_a", out_op_a, 32'd0);
    chk("rst_op_b", out_op_b, 32'd0);
    chk("rst_imm", out_imm, 32'd0);
    chk("rst_ctrl_rd_we", {21'd0, out_ctrl, out_rd, out_rd_we}, 32'd0);

    // 2 Back-to-back independent instructions.
    instr(1, 3'd1, 1, 3'd2, 1, 3'd3, 1, 32'hAAAA, 8'h11);
    chk("b2b_ready0", {31'd0, in_ready}, 32'd1);
    tick();
    chk("b2b_valid0", {31'd0, out_valid}, 32'd1);
    chk("b2b_op_a0", out_op_a, 32'd5);
    chk("b2b_op_b0", out_op_b, 32'd7);
    chk("b2b_meta0", {out_imm[15:0], out_ctrl, 4'd0, out_rd, out_rd_we}, 32'hAAAA_1107);
    instr(1, 3'd4, 1, 3'd5, 1, 3'd6, 1, 32'hBBBB, 8'h22);
    chk("b2b_ready1", {31'd0, in_ready}, 32'd1);
    tick();
    chk("b2b_op_a1", out_op_a, 32'h104);
    chk("b2b_op_b1", out_op_b, 32'h105);
    chk("b2b_rd1", {29'd0, out_rd}, 32'd6);

    // 3 RAW stall on r3 until writeback, then forward.
    instr(1, 3'd3, 1, 3'd0, 0, 3'd7, 1, 32'h0, 8'h33);
    chk("raw_stall0", {31'd0, in_ready}, 32'd0);
    tick();
    chk("raw_drained", {31'd0, out_valid}, 32'd0);
    chk("raw_stall1", {31'd0, in_ready}, 32'd0);
    tick();
    wb_en = 1; wb_dest = 3'd3; wb_data = 32'h1234; #1;
    chk("raw_wb_ready", {31'd0, in_ready}, 32'd1);
    tick();
    wb_en = 0;
    chk("raw_fwd_valid", {31'd0, out_valid}, 32'd1);
    chk("raw_fwd_op_a", out_op_a, 32'h1234);
    chk("raw_fwd_rd", {29'd0, out_rd}, 32'd7);
    // Retire r6 and r7 with no instruction present.
    instr(0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 32'h0, 8'h0);
    wb_en = 1; wb_dest = 3'd6; tick();
    wb_dest = 3'd7; tick();
    wb_en = 0;
    chk("idle_valid", {31'd0, out_valid}, 32'd0);

    // 4 Backpressure.
    instr(1, 3'd1, 1, 3'd2, 1, 3'd4, 1, 32'hCCCC, 8'h44);
    tick();
    chk("bp_issue_op_a", out_op_a, 32'd5);
    out_ready = 0;
    instr(1, 3'd0, 1, 3'd1, 1, 3'd5, 1, 32'hDDDD, 8'h55);
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready", {31'd0, in_ready}, 32'd0);
      tick();
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold", {out_imm[15:0], out_ctrl, 4'd0, out_rd, out_rd_we}, 32'hCCCC_4409);
      chk("bp_hold_op_a", out_op_a, 32'd5);
    end
    out_ready = 1; #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("bp_next_rd", {29'd0, out_rd}, 32'd5);
    chk("bp_next_op_a", out_op_a, 32'h100);
    chk("bp_next_op_b", out_op_b, 32'd5);

    // 5 Flush the held rd=5 entry; independent instruction present must not fire.
    instr(1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 32'hEEEE, 8'h66);
    flush = 1; #1;
    chk("flush_ready", {31'd0, in_ready}, 32'd0);
    tick();
    flush = 0;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_no_fire", out_imm, 32'hDDDD);
    instr(1, 3'd4, 1, 3'd0, 0, 3'd0, 0, 32'h0, 8'h0);
    chk("flush_r4_busy", {31'd0, in_ready}, 32'd0);
    instr(1, 3'd5, 1, 3'd0, 0, 3'd0, 0, 32'h5, 8'h77);
    chk("flush_r5_free", {31'd0, in_ready}, 32'd1);
    tick();
    chk("flush_r5_issue", {31'd0, out_valid}, 32'd1);
    chk("flush_r5_op_a", out_op_a, 32'h105);

    // 6 Set/clear collision on r2.
    instr(1, 3'd0, 0, 3'd0, 0, 3'd2, 1, 32'h0, 8'h88);
    tick();
    instr(1, 3'd0, 0, 3'd2, 1, 3'd2, 1, 32'h6, 8'h99);
    wb_en = 1; wb_dest = 3'd2; wb_data = 32'hBEEF; #1;
    chk("coll_waw_ready", {31'd0, in_ready}, 32'd1);
    tick();
    wb_en = 0;
    chk("coll_rd", {29'd0, out_rd}, 32'd2);
    chk("coll_fwd_op_b", out_op_b, 32'hBEEF);
    instr(1, 3'd2, 1, 3'd0, 0, 3'd0, 0, 32'h0, 8'h0);
    chk("coll_r2_busy", {31'd0, in_ready}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
